// File: rtl/video32bit_in_packer.sv
// video32bit_in_packer
// Write-side capture stage in front of the DDR frame buffer. It takes 32-bit
// pixels with VGA-style timing and packs each pixel pair into one 64-bit word.
// The first pixel of a pair goes in bits [63:32]. Once per frame it issues a
// write request that carries the base address and geometry. It also pulses
// req_end when the last line of the frame has been stored.
//
// Ports:
//   pclk, prst_n             pixel clock, asynchronous active-low reset
//   invsync                  vertical sync, high during vertical blanking
//   inhsync                  horizontal sync, unused (kept for port symmetry)
//   inde, indata             pixel valid strobe and 32-bit pixel
//   video_width/height       frame geometry, latched during vertical blanking
//   video_baseaddr           frame base address, latched during vertical blanking
//   sync_fifo_full           DDR write FIFO full (already in the pclk domain)
//   wr_req                   one-cycle frame write request
//   wr_data, wr_data_en      packed pixel pair and its write strobe
//   baseaddr                 latched base address
//   ddr_line_length          64-bit words per line = ceil(width/2)
//   ddr_col_length           latched line count
//   req_end                  one-cycle end-of-frame pulse
//   overflow                 sticky: a word was dropped because the FIFO was full
module video32bit_in_packer #(
  parameter int ADDR_BITS = 25
) (
  input  logic                 pclk,
  input  logic                 prst_n,
  input  logic                 invsync,
  input  logic                 inhsync,
  input  logic                 inde,
  input  logic [31:0]          indata,
  input  logic [23:0]          video_width,
  input  logic [11:0]          video_height,
  input  logic [ADDR_BITS-1:0] video_baseaddr,
  input  logic                 sync_fifo_full,
  output logic                 wr_req,
  output logic [63:0]          wr_data,
  output logic                 wr_data_en,
  output logic [ADDR_BITS-1:0] baseaddr,
  output logic [23:0]          ddr_line_length,
  output logic [11:0]          ddr_col_length,
  output logic                 req_end,
  output logic                 overflow
);

  typedef enum logic [2:0] {IDLE, FRAME, ACTIVE, FEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   vs_d_q, vs_d_d;
  logic                   inde_d_q, inde_d_d;
  logic [23:0]            sync_width_q, sync_width_d;
  logic [11:0]            col_length_q, col_length_d;
  logic [ADDR_BITS-1:0]   baseaddr_q, baseaddr_d;
  logic                   cfg_seen_q, cfg_seen_d;
  logic [23:0]            line_length_q, line_length_d;
  logic [23:0]            pix_cnt_q, pix_cnt_d;
  logic [11:0]            line_cnt_q, line_cnt_d;
  logic                   half_q, half_d;
  logic [31:0]            hold_q, hold_d;
  logic                   fend_pend_q, fend_pend_d;
  logic [63:0]            wr_data_q, wr_data_d;
  logic                   wr_data_en_q, wr_data_en_d;
  logic                   overflow_q, overflow_d;

  logic                   vs_fall, vs_rise, line_end, pix_ok, last_line;
  logic                   word_due;
  logic [63:0]            word_val;
  logic                   unused_inputs;

  assign unused_inputs = inhsync;

  always_comb begin
    vs_fall   = vs_d_q & ~invsync;
    vs_rise   = ~vs_d_q & invsync;
    line_end  = inde_d_q & ~inde;
    pix_ok    = inde && (pix_cnt_q < sync_width_q);
    // A zero-width frame finishes on its first line end, whatever the height.
    last_line = (({1'b0, line_cnt_q} + 13'd1) >= {1'b0, col_length_q}) ||
                (sync_width_q == 24'd0);

    state_d       = state_q;
    vs_d_d        = invsync;
    inde_d_d      = inde;
    sync_width_d  = sync_width_q;
    col_length_d  = col_length_q;
    baseaddr_d    = baseaddr_q;
    cfg_seen_d    = cfg_seen_q;
    line_length_d = {1'b0, sync_width_q[23:1]} + {23'd0, sync_width_q[0]};
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    half_d        = half_q;
    hold_d        = hold_q;
    fend_pend_d   = fend_pend_q;
    wr_data_d     = wr_data_q;
    wr_data_en_d  = 1'b0;
    overflow_d    = overflow_q;
    word_due      = 1'b0;
    word_val      = 64'd0;

    if (invsync) begin
      sync_width_d = video_width;
      col_length_d = video_height;
      baseaddr_d   = video_baseaddr;
      cfg_seen_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_cnt_d  = 12'd0;
        pix_cnt_d   = 24'd0;
        half_d      = 1'b0;
        fend_pend_d = 1'b0;
        if (vs_fall) state_d = FRAME;
      end
      FRAME: begin
        line_cnt_d  = 12'd0;
        pix_cnt_d   = 24'd0;
        half_d      = 1'b0;
        fend_pend_d = 1'b0;
        state_d     = ACTIVE;
      end
      ACTIVE: begin
        // The pad word of the last line goes out first, then FEND.
        if (fend_pend_q) begin
          state_d = FEND;
        end else if (line_cnt_q >= col_length_q) begin
          state_d = FEND;
        end else if (line_end) begin
          line_cnt_d = line_cnt_q + 12'd1;
          pix_cnt_d  = 24'd0;
          half_d     = 1'b0;
          if (half_q) begin
            word_due = 1'b1;
            word_val = {hold_q, 32'd0};
          end
          if (last_line) begin
            if (half_q) fend_pend_d = 1'b1;
            else        state_d     = FEND;
          end
        end else if (pix_ok) begin
          pix_cnt_d = pix_cnt_q + 24'd1;
          if (!half_q) begin
            hold_d = indata;
            half_d = 1'b1;
          end else begin
            half_d   = 1'b0;
            word_due = 1'b1;
            word_val = {hold_q, indata};
          end
        end
      end
      FEND: begin
        fend_pend_d = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Vertical blanking aborts any frame in progress and drops its partial word.
    if (vs_rise) begin
      state_d  = IDLE;
      word_due = 1'b0;
    end

    if (vs_fall) overflow_d = 1'b0;

    // No back-pressure on video: a word due while the FIFO is full is lost.
    if (word_due) begin
      if (sync_fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_data_en_d = 1'b1;
        wr_data_d    = word_val;
      end
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q       <= IDLE;
      vs_d_q        <= 1'b0;
      inde_d_q      <= 1'b0;
      sync_width_q  <= 24'd0;
      col_length_q  <= 12'd0;
      baseaddr_q    <= '0;
      cfg_seen_q    <= 1'b0;
      line_length_q <= 24'd0;
      pix_cnt_q     <= 24'd0;
      line_cnt_q    <= 12'd0;
      half_q        <= 1'b0;
      hold_q        <= 32'd0;
      fend_pend_q   <= 1'b0;
      wr_data_q     <= 64'd0;
      wr_data_en_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_d_q        <= vs_d_d;
      inde_d_q      <= inde_d_d;
      sync_width_q  <= sync_width_d;
      col_length_q  <= col_length_d;
      baseaddr_q    <= baseaddr_d;
      cfg_seen_q    <= cfg_seen_d;
      line_length_q <= line_length_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      half_q        <= half_d;
      hold_q        <= hold_d;
      fend_pend_q   <= fend_pend_d;
      wr_data_q     <= wr_data_d;
      wr_data_en_q  <= wr_data_en_d;
      overflow_q    <= overflow_d;
    end
  end

  // Until the first blanking period latches an address, the output follows the
  // input. This gives baseaddr = video_baseaddr while reset is asserted.
  assign baseaddr        = cfg_seen_q ? baseaddr_q : video_baseaddr;
  assign wr_req          = (state_q == FRAME);
  assign req_end         = (state_q == FEND);
  assign wr_data         = wr_data_q;
  assign wr_data_en      = wr_data_en_q;
  assign ddr_line_length = line_length_q;
  assign ddr_col_length  = col_length_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_video32bit_in_packer.sv
// tb_video32bit_in_packer
// Directed, table-driven bench for video32bit_in_packer. Each record gives the
// inputs for one pclk cycle and the outputs expected just after that edge.
module tb_video32bit_in_packer;

  logic        pclk;
  logic        prst_n;
  logic        invsync;
  logic        inhsync;
  logic        inde;
  logic [31:0] indata;
  logic [23:0] video_width;
  logic [11:0] video_height;
  logic [24:0] video_baseaddr;
  logic        sync_fifo_full;
  logic        wr_req;
  logic [63:0] wr_data;
  logic        wr_data_en;
  logic [24:0] baseaddr;
  logic [23:0] ddr_line_length;
  logic [11:0] ddr_col_length;
  logic        req_end;
  logic        overflow;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        vs;
    logic        de;
    logic [31:0] data;
    logic        full;
    logic        expReq;
    logic        expEn;
    logic [63:0] expData;
    logic        expEnd;
    logic        expOvf;
  } vec_t;

  vec_t vecs[$];

  video32bit_in_packer #(.ADDR_BITS(25)) dut (
    .pclk            (pclk),
    .prst_n          (prst_n),
    .invsync         (invsync),
    .inhsync         (inhsync),
    .inde            (inde),
    .indata          (indata),
    .video_width     (video_width),
    .video_height    (video_height),
    .video_baseaddr  (video_baseaddr),
    .sync_fifo_full  (sync_fifo_full),
    .wr_req          (wr_req),
    .wr_data         (wr_data),
    .wr_data_en      (wr_data_en),
    .baseaddr        (baseaddr),
    .ddr_line_length (ddr_line_length),
    .ddr_col_length  (ddr_col_length),
    .req_end         (req_end),
    .overflow        (overflow)
  );

  // Free-running pixel clock, 10 time units per cycle.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] pw(input logic [31:0] a, input logic [31:0] b);
    return {a, b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic vs, input logic de,
                               input logic [31:0] data, input logic full);
    invsync        = vs;
    inde           = de;
    indata         = data;
    sync_fifo_full = full;
    @(posedge pclk);
    #1;
  endtask

  task automatic add(input logic vs, input logic de, input logic [31:0] d,
                     input logic full, input logic req, input logic en,
                     input logic [63:0] wd, input logic rend, input logic ovf);
    vec_t v;
    v.vs = vs; v.de = de; v.data = d; v.full = full;
    v.expReq = req; v.expEn = en; v.expData = wd; v.expEnd = rend; v.expOvf = ovf;
    vecs.push_back(v);
  endtask

  task automatic runList(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vs, vecs[i].de, vecs[i].data, vecs[i].full);
      checkOutput($sformatf("%s[%0d] wr_req", name, i), 64'(wr_req), 64'(vecs[i].expReq));
      checkOutput($sformatf("%s[%0d] wr_data_en", name, i), 64'(wr_data_en), 64'(vecs[i].expEn));
      checkOutput($sformatf("%s[%0d] wr_data", name, i), wr_data, vecs[i].expData);
      checkOutput($sformatf("%s[%0d] req_end", name, i), 64'(req_end), 64'(vecs[i].expEnd));
      checkOutput($sformatf("%s[%0d] overflow", name, i), 64'(overflow), 64'(vecs[i].expOvf));
    end
    vecs.delete();
  endtask

  task automatic setConfig(input logic [23:0] w, input logic [11:0] h,
                           input logic [24:0] base);
    video_width    = w;
    video_height   = h;
    video_baseaddr = base;
    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    prst_n         = 1'b0;
    invsync        = 1'b1;
    inhsync        = 1'b0;
    inde           = 1'b0;
    indata         = 32'd0;
    video_width    = 24'd4;
    video_height   = 12'd2;
    video_baseaddr = 25'h0ABCDEF;
    sync_fifo_full = 1'b0;

    #2;
    checkOutput("reset wr_req", 64'(wr_req), 64'd0);
    checkOutput("reset wr_data_en", 64'(wr_data_en), 64'd0);
    checkOutput("reset wr_data", wr_data, 64'd0);
    checkOutput("reset req_end", 64'(req_end), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset line_length", 64'(ddr_line_length), 64'd0);
    checkOutput("reset col_length", 64'(ddr_col_length), 64'd0);
    checkOutput("reset baseaddr", 64'(baseaddr), 64'h0ABCDEF);

    @(posedge pclk); #1;
    @(posedge pclk); #1;
    prst_n = 1'b1;

    // Frame A: width 4, height 2, pixels 1..8.
    setConfig(24'd4, 12'd2, 25'h0ABCDEF);
    checkOutput("A line_length", 64'(ddr_line_length), 64'd2);
    checkOutput("A col_length", 64'(ddr_col_length), 64'd2);
    checkOutput("A baseaddr", 64'(baseaddr), 64'h0ABCDEF);
    add(0,0,0,0, 1,0,64'd0,0,0);
    add(0,0,0,0, 0,0,64'd0,0,0);
    add(0,1,1,0, 0,0,64'd0,0,0);
    add(0,1,2,0, 0,1,pw(1,2),0,0);
    add(0,1,3,0, 0,0,pw(1,2),0,0);
    add(0,1,4,0, 0,1,pw(3,4),0,0);
    add(0,0,0,0, 0,0,pw(3,4),0,0);
    add(0,0,0,0, 0,0,pw(3,4),0,0);
    add(0,1,5,0, 0,0,pw(3,4),0,0);
    add(0,1,6,0, 0,1,pw(5,6),0,0);
    add(0,1,7,0, 0,0,pw(5,6),0,0);
    add(0,1,8,0, 0,1,pw(7,8),0,0);
    add(0,0,0,0, 0,0,pw(7,8),1,0);
    add(0,0,0,0, 0,0,pw(7,8),0,0);
    add(0,0,0,0, 0,0,pw(7,8),0,0);
    add(1,0,0,0, 0,0,pw(7,8),0,0);
    add(1,0,0,0, 0,0,pw(7,8),0,0);
    runList("frameA");

    // Odd width 3, height 1: pad word {C,0} one cycle after inde falls.
    setConfig(24'd3, 12'd1, 25'h0123456);
    checkOutput("odd line_length", 64'(ddr_line_length), 64'd2);
    checkOutput("odd col_length", 64'(ddr_col_length), 64'd1);
    add(0,0,0,0, 1,0,pw(7,8),0,0);
    add(0,0,0,0, 0,0,pw(7,8),0,0);
    runList("oddA");
    video_baseaddr = 25'h1FFFFFF;
    add(0,1,32'hAAAA0001,0, 0,0,pw(7,8),0,0);
    add(0,1,32'hBBBB0002,0, 0,1,pw(32'hAAAA0001,32'hBBBB0002),0,0);
    add(0,1,32'hCCCC0003,0, 0,0,pw(32'hAAAA0001,32'hBBBB0002),0,0);
    add(0,0,0,0, 0,1,pw(32'hCCCC0003,32'd0),0,0);
    add(0,0,0,0, 0,0,pw(32'hCCCC0003,32'd0),1,0);
    add(0,0,0,0, 0,0,pw(32'hCCCC0003,32'd0),0,0);
    runList("oddB");
    checkOutput("odd baseaddr held", 64'(baseaddr), 64'h0123456);

    // Width 4 with 6 pixels per line: extra pixels ignored, next line restarts.
    setConfig(24'd4, 12'd2, 25'h0123456);
    add(0,0,0,0, 1,0,pw(32'hCCCC0003,32'd0),0,0);
    add(0,0,0,0, 0,0,pw(32'hCCCC0003,32'd0),0,0);
    add(0,1,1,0, 0,0,pw(32'hCCCC0003,32'd0),0,0);
    add(0,1,2,0, 0,1,pw(1,2),0,0);
    add(0,1,3,0, 0,0,pw(1,2),0,0);
    add(0,1,4,0, 0,1,pw(3,4),0,0);
    add(0,1,5,0, 0,0,pw(3,4),0,0);
    add(0,1,6,0, 0,0,pw(3,4),0,0);
    add(0,0,0,0, 0,0,pw(3,4),0,0);
    add(0,0,0,0, 0,0,pw(3,4),0,0);
    add(0,1,9,0, 0,0,pw(3,4),0,0);
    add(0,1,10,0, 0,1,pw(9,10),0,0);
    add(0,1,11,0, 0,0,pw(9,10),0,0);
    add(0,1,12,0, 0,1,pw(11,12),0,0);
    add(0,0,0,0, 0,0,pw(11,12),1,0);
    add(0,0,0,0, 0,0,pw(11,12),0,0);
    runList("trunc");

    // FIFO full on the second word: dropped, overflow sticky until vs_fall.
    setConfig(24'd4, 12'd1, 25'h0123456);
    add(0,0,0,0, 1,0,pw(11,12),0,0);
    add(0,0,0,0, 0,0,pw(11,12),0,0);
    add(0,1,1,0, 0,0,pw(11,12),0,0);
    add(0,1,2,0, 0,1,pw(1,2),0,0);
    add(0,1,3,0, 0,0,pw(1,2),0,0);
    add(0,1,4,1, 0,0,pw(1,2),0,1);
    add(0,0,0,0, 0,0,pw(1,2),1,1);
    add(0,0,0,0, 0,0,pw(1,2),0,1);
    add(1,0,0,0, 0,0,pw(1,2),0,1);
    add(1,0,0,0, 0,0,pw(1,2),0,1);
    add(1,0,0,0, 0,0,pw(1,2),0,1);
    runList("ovfA");
    video_height = 12'd2;
    add(1,0,0,0, 0,0,pw(1,2),0,1);
    add(1,0,0,0, 0,0,pw(1,2),0,1);
    add(0,0,0,0, 1,0,pw(1,2),0,0);
    add(0,0,0,0, 0,0,pw(1,2),0,0);
    // Line 1 complete, then abort mid line 2 with a half word pending.
    add(0,1,1,0, 0,0,pw(1,2),0,0);
    add(0,1,2,0, 0,1,pw(1,2),0,0);
    add(0,1,3,0, 0,0,pw(1,2),0,0);
    add(0,1,4,0, 0,1,pw(3,4),0,0);
    add(0,0,0,0, 0,0,pw(3,4),0,0);
    add(0,1,5,0, 0,0,pw(3,4),0,0);
    add(0,1,6,0, 0,1,pw(5,6),0,0);
    add(0,1,7,0, 0,0,pw(5,6),0,0);
    add(1,1,8,0, 0,0,pw(5,6),0,0);
    add(1,0,0,0, 0,0,pw(5,6),0,0);
    add(1,0,0,0, 0,0,pw(5,6),0,0);
    add(1,0,0,0, 0,0,pw(5,6),0,0);
    // Clean frame after the abort: must take two full lines.
    add(0,0,0,0, 1,0,pw(5,6),0,0);
    add(0,0,0,0, 0,0,pw(5,6),0,0);
    add(0,1,32'h11,0, 0,0,pw(5,6),0,0);
    add(0,1,32'h12,0, 0,1,pw(32'h11,32'h12),0,0);
    add(0,1,32'h13,0, 0,0,pw(32'h11,32'h12),0,0);
    add(0,1,32'h14,0, 0,1,pw(32'h13,32'h14),0,0);
    add(0,0,0,0, 0,0,pw(32'h13,32'h14),0,0);
    add(0,0,0,0, 0,0,pw(32'h13,32'h14),0,0);
    add(0,1,32'h15,0, 0,0,pw(32'h13,32'h14),0,0);
    add(0,1,32'h16,0, 0,1,pw(32'h15,32'h16),0,0);
    add(0,1,32'h17,0, 0,0,pw(32'h15,32'h16),0,0);
    add(0,1,32'h18,0, 0,1,pw(32'h17,32'h18),0,0);
    add(0,0,0,0, 0,0,pw(32'h17,32'h18),1,0);
    add(0,0,0,0, 0,0,pw(32'h17,32'h18),0,0);
    runList("ovfB_abort");

    // Reset asserted mid-frame with overflow set.
    add(1,0,0,0, 0,0,pw(32'h17,32'h18),0,0);
    add(1,0,0,0, 0,0,pw(32'h17,32'h18),0,0);
    add(0,0,0,0, 1,0,pw(32'h17,32'h18),0,0);
    add(0,0,0,0, 0,0,pw(32'h17,32'h18),0,0);
    add(0,1,1,0, 0,0,pw(32'h17,32'h18),0,0);
    add(0,1,2,1, 0,0,pw(32'h17,32'h18),0,1);
    add(0,1,3,0, 0,0,pw(32'h17,32'h18),0,1);
    runList("rstA");
    #3;
    prst_n = 1'b0;
    #1;
    checkOutput("async rst wr_data_en", 64'(wr_data_en), 64'd0);
    checkOutput("async rst wr_data", wr_data, 64'd0);
    checkOutput("async rst overflow", 64'(overflow), 64'd0);
    checkOutput("async rst wr_req", 64'(wr_req), 64'd0);
    checkOutput("async rst req_end", 64'(req_end), 64'd0);
    checkOutput("async rst line_length", 64'(ddr_line_length), 64'd0);
    checkOutput("async rst col_length", 64'(ddr_col_length), 64'd0);
    checkOutput("async rst baseaddr", 64'(baseaddr), 64'(video_baseaddr));
    @(posedge pclk); #1;
    prst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, i[0], 32'(i + 1), 1'b0);
      checkOutput($sformatf("post rst[%0d] wr_req", i), 64'(wr_req), 64'd0);
      checkOutput($sformatf("post rst[%0d] wr_data_en", i), 64'(wr_data_en), 64'd0);
      checkOutput($sformatf("post rst[%0d] req_end", i), 64'(req_end), 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("post rst blank wr_req", 64'(wr_req), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("post rst vs_fall wr_req", 64'(wr_req), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/video32bit_in_packer.md
Name: video32bit_in_packer

Overview:
- Write-side capture stage upstream of the DDR frame buffer; the 64-bit read-out/unpack stage consumes what it stores.
- Takes 32-bit pixels with VGA-style timing on pclk and packs pixel pairs into 64-bit words. The first pixel of each pair goes in bits [63:32].
- Pushes words into the DDR write FIFO and issues one frame-level write request per frame with base address and geometry.
- Signals frame end to the DDR memory controller.

Parameters:
- ADDR_BITS, 25, width of the DDR base address.

Ports:
- pclk  input  1  pixel clock
- prst_n  input  1  asynchronous active-low reset
- invsync  input  1  vertical sync; high = vertical blanking
- inhsync  input  1  horizontal sync; not used by the logic, kept for port symmetry
- inde  input  1  data enable; pixel valid when high
- indata  input  32  pixel data
- video_width  input  24  pixels per line
- video_height  input  12  lines per frame
- video_baseaddr  input  ADDR_BITS  frame base address in DDR
- sync_fifo_full  input  1  DDR write FIFO full, already synchronised to pclk
- wr_req  output  1  one-cycle frame write request
- wr_data  output  64  packed pixel pair
- wr_data_en  output  1  write strobe for wr_data
- baseaddr  output  ADDR_BITS  latched frame base address
- ddr_line_length  output  24  64-bit words per line = ceil(width/2)
- ddr_col_length  output  12  latched line count
- req_end  output  1  one-cycle end-of-frame pulse
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full

Behaviour:
- Reset: prst_n asynchronous, active-low. All outputs 0; baseaddr = video_baseaddr; FSM in IDLE.
- Config latch:
  - While invsync=1 every cycle: sync_width<=video_width, col_length<=video_height, baseaddr<=video_baseaddr.
  - The latched values are held while invsync=0.
  - ddr_line_length is registered: sync_width[23:1] + sync_width[0].
  - ddr_col_length = col_length.
- Edge detect: vs_d registered copy of invsync.
  - vs_fall = vs_d & ~invsync
  - vs_rise = ~vs_d & invsync
- FSM states IDLE, FRAME, ACTIVE, FEND, DONE:
  - IDLE -> FRAME on vs_fall.
  - FRAME lasts exactly 1 cycle; wr_req=1 in this cycle only; then -> ACTIVE.
  - ACTIVE -> FEND when line_cnt reaches col_length at a line end.
  - FEND lasts 1 cycle; req_end=1 in this cycle only; then -> DONE.
  - DONE holds until vs_rise, then -> IDLE.
  - vs_rise in any state forces IDLE next cycle. This has priority over every other transition.
  - On this abort: partial word discarded, no wr_data_en, no req_end.
- Pixel packing (ACTIVE only; inde ignored in other states):
  - pix_cnt (24 bit) counts accepted pixels in the line.
  - A pixel is accepted when inde=1 and pix_cnt < sync_width. Pixels beyond sync_width are ignored.
  - Even-index pixel -> hold[63:32], half flag set.
  - Odd-index pixel -> wr_data = {hold[63:32], indata}, wr_data_en=1 on the next cycle (latency 1), half flag cleared.
  - Line end = inde falling edge (registered inde_d & ~inde) in ACTIVE.
  - If half flag is set at line end: emit {hold[63:32], 32'd0} with wr_data_en=1 the cycle after line end (odd width padding).
  - pix_cnt and half flag clear at line end.
  - line_cnt (12 bit) increments at each line end; it clears in IDLE/FRAME.
  - Last line detected when line_cnt+1 == col_length at a line end. FEND is entered the cycle after the pad word, or the cycle after line end if there is no pad.
  - A line end with pix_cnt==0 (inde pulse of zero accepted pixels) is still counted as a line.
  - sync_width==0 or col_length==0: no words written; FRAME -> ACTIVE -> FEND on the first line end. With col_length==0 the transition happens immediately (line_cnt compare >=).
- Overflow:
  - If a word is due while sync_fifo_full=1, wr_data_en stays 0 and the word is dropped.
  - overflow is set and stays set until the next vs_fall.
  - Packing continues; there is no back-pressure on video.
- wr_data holds its last value when wr_data_en=0.

Test Plan:
- width=4, height=2, pixels 0x1..0x8, FIFO never full:
  - wr_req 1 cycle after vs_fall.
  - wr_data_en 4 times: {1,2},{3,4},{5,6},{7,8}, each 1 cycle after the odd pixel.
  - req_end single pulse after line 2.
  - ddr_line_length=2, ddr_col_length=2.
- width=3, height=1, pixels A,B,C:
  - Words {A,B} and {C,0}; the second word arrives 1 cycle after inde falls.
  - ddr_line_length=2.
- width=4 but inde high for 6 pixels:
  - Only {1,2},{3,4} written; pixels 5,6 ignored.
  - Next line starts at pix_cnt=0.
- sync_fifo_full=1 during the 2nd word:
  - That word is not strobed; overflow=1 and remains set through the frame.
  - overflow clears at the next vs_fall.
- invsync rises mid-line with a half word pending:
  - No wr_data_en and no req_end.
  - FSM returns to IDLE; next frame starts cleanly with line_cnt=0.
- prst_n asserted mid-frame:
  - All outputs 0 immediately (asynchronous).
  - After release, nothing happens until a vs_fall.
